fab_clk_div_gen: RTL and testbench
==================================

FAB_CLK_DIV_GEN -- requirements
Module: fab_clk_div_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent divider channels (1-16).
REQ-002 SHALL have parameter DIV_W, default 16: divisor width in bits.
REQ-003 SHALL have parameter DEF_DIV, default 0: divisor loaded into every channel at reset.
REQ-004 SHALL have parameter LOCK_CNT, default 4: consecutive ticks at an unchanged divisor before lock asserts.
REQ-005 SHALL have PCLK  input  1  sole clock; all state on its rising edge.
REQ-006 SHALL have PRESERN  input  1  reset; one clock, reset is synchronous and active-low.
REQ-007 SHALL have cfg_wr  input  1  divisor write strobe, accepted only when cfg_ready=1.
REQ-008 SHALL have cfg_ch  input  CH_W=max(1,clog2(NUM_CH))  target channel of the write.
REQ-009 SHALL have cfg_div  input  DIV_W  new divisor D; period = D+1 PCLK cycles.
REQ-010 SHALL have cfg_ready  output  1  combinational: 1 iff cfg_ch<NUM_CH and no pending divisor on cfg_ch.
REQ-011 SHALL have ch_en  input  NUM_CH  per-channel run enable.
REQ-012 SHALL have tick  output  NUM_CH  one-cycle enable pulse per period.
REQ-013 SHALL have clk_out  output  NUM_CH  registered square wave toggling on every tick (period 2*(D+1)).
REQ-014 SHALL have lock  output  NUM_CH  channel running stably at its active divisor.
REQ-015 SHALL have all_lock  output  1  registered AND of lock over all channels.

Function
REQ-016 Each channel SHALL hold cnt (DIV_W bits), div_act, div_pend, pend flag, clk_out, lock counter.
REQ-017 With ch_en=1, cnt SHALL increment each cycle; tick=1 (registered) in the cycle cnt==div_act, and cnt returns to 0 next cycle.
REQ-018 D=0 SHALL give tick=1 every enabled cycle (bypass); clk_out = PCLK/2.
REQ-019 First tick after ch_en 0->1 SHALL occur exactly D+1 cycles after the enabling edge.
REQ-020 With ch_en=0: cnt held 0, tick=0, clk_out=0, lock=0, lock counter 0.
REQ-021 Accepted write (cfg_wr & cfg_ready) SHALL load div_pend and set pend for cfg_ch; otherwise the write SHALL be ignored with no state change.
REQ-022 Pending divisor SHALL transfer to div_act on the cycle after the next tick (glitch-free, at period boundary); pend clears then.
REQ-023 Write coinciding with a tick SHALL NOT affect that tick; it applies at the following tick.
REQ-024 Pending on a disabled channel SHALL apply on the next cycle.
REQ-025 Applying a divisor (even equal value) SHALL clear lock and lock counter.
REQ-026 Lock counter SHALL count ticks, saturate at LOCK_CNT; lock=1 when counter==LOCK_CNT.
REQ-027 ch_en falling mid-period SHALL abort the period with no tick; clk_out forced 0 next cycle.

Reset
REQ-028 While PRESERN=0 at a PCLK edge: cnt=0, div_act=DEF_DIV, pend=0, tick=0, clk_out=0, lock=0, all_lock=0.
REQ-029 Reset SHALL dominate cfg_wr and ch_en; reset mid-period discards pending writes.
REQ-030 cfg_ready SHALL read 1 for valid cfg_ch after reset.

Structure
REQ-031 Package fab_clk_pkg SHALL hold default parameter constants, the clog2 function, and the channel-state typedef.
REQ-032 One sub-module fab_clk_div_ch SHALL implement a single channel; top generates NUM_CH instances plus cfg decode and all_lock.

Verification
REQ-033 Reset, ch_en=1 on ch0, DEF_DIV=0 -> tick0 every cycle from cycle 1, clk_out0 toggles each cycle, lock0 after 4 ticks.
REQ-034 Write ch1 D=3, enable ch1 -> tick1 every 4 cycles, clk_out1 period 8, lock1 at 4th tick, all_lock only when all channels locked.
REQ-035 Ch2 running D=9, write D=2 mid-period at cnt=4 -> cfg_ready(ch2)=0, period completes at 10 cycles, then 3-cycle period; lock2 drops and reasserts after 4 ticks.
REQ-036 Write on tick cycle, then second write before apply -> second ignored (cfg_ready=0), first value applied at following tick.
REQ-037 cfg_ch=NUM_CH with cfg_wr=1 -> cfg_ready=0, no channel changes; PRESERN low mid-period -> all outputs 0 next cycle, divisors back to DEF_DIV.

Source files
------------

// File: rtl/fab_clk_pkg.sv
// fab_clk_pkg: default parameters, clog2 helper and per-channel flag type for fab_clk_div_gen
package fab_clk_pkg;
   localparam int FAB_NUM_CH   = 4;
   localparam int FAB_DIV_W    = 16;
   localparam int FAB_DEF_DIV  = 0;
   localparam int FAB_LOCK_CNT = 4;
   typedef struct packed {
      logic pend;
      logic tick;
      logic clk_out;
   } ch_flags_t;
   function automatic int clog2(input int n);
      int r = 0;
      for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
      return r;
   endfunction
endpackage

// File: rtl/fab_clk_div_ch.sv
// fab_clk_div_ch: one divider channel (counter, active/pending divisor, square wave, lock tracking)
// Ports: PCLK/PRESERN clock and sync active-low reset; ch_en run enable; wr/wr_div accepted divisor write;
//        pend pending-divisor flag; tick period pulse; clk_out square wave; lock stable-run indicator.
module fab_clk_div_ch
   import fab_clk_pkg::*;
#(
   parameter int DIV_W    = FAB_DIV_W,
   parameter int DEF_DIV  = FAB_DEF_DIV,
   parameter int LOCK_CNT = FAB_LOCK_CNT
) (
   input  logic             PCLK,
   input  logic             PRESERN,
   input  logic             ch_en,
   input  logic             wr,
   input  logic [DIV_W-1:0] wr_div,
   output logic             pend,
   output logic             tick,
   output logic             clk_out,
   output logic             lock
);
   localparam int LW = (clog2(LOCK_CNT + 1) > 0) ? clog2(LOCK_CNT + 1) : 1;
   logic [DIV_W-1:0] cnt_q, cnt_d, act_q, act_d, pdiv_q, pdiv_d;
   logic [LW-1:0]    lc_q, lc_d, lc_base;
   ch_flags_t        f_q, f_d;
   logic             lock_q, lock_d, apply;
   // The new divisor takes effect in the cycle after a tick, so the comparison
   // that starts the next period already uses it (also makes D=0 work at once).
   always_comb begin
      apply       = f_q.pend & (f_q.tick | ~ch_en);
      act_d       = apply ? pdiv_q : act_q;
      f_d.tick    = ch_en & (cnt_q == act_d);
      cnt_d       = (ch_en & ~f_d.tick) ? cnt_q + 1'b1 : '0;
      f_d.clk_out = ch_en & (f_q.clk_out ^ f_d.tick);
      f_d.pend    = wr | (f_q.pend & ~apply);
      pdiv_d      = wr ? wr_div : pdiv_q;
      lc_base     = apply ? '0 : lc_q;
      lc_d        = ~ch_en ? '0 : (f_d.tick && lc_base != LW'(LOCK_CNT)) ? lc_base + 1'b1 : lc_base;
      lock_d      = ch_en & (lc_d == LW'(LOCK_CNT));
   end
   always_ff @(posedge PCLK) begin
      if (!PRESERN) begin
         cnt_q  <= '0;
         act_q  <= DIV_W'(DEF_DIV);
         pdiv_q <= '0;
         f_q    <= '0;
         lc_q   <= '0;
         lock_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         act_q  <= act_d;
         pdiv_q <= pdiv_d;
         f_q    <= f_d;
         lc_q   <= lc_d;
         lock_q <= lock_d;
      end
   end
   assign pend    = f_q.pend;
   assign tick    = f_q.tick;
   assign clk_out = f_q.clk_out;
   assign lock    = lock_q;
endmodule

// File: rtl/fab_clk_div_gen.sv
// fab_clk_div_gen: NUM_CH independent programmable clock-enable / square-wave dividers
// Ports: PCLK/PRESERN clock and sync active-low reset; cfg_wr/cfg_ch/cfg_div divisor write, cfg_ready accept;
//        ch_en per-channel enable; tick, clk_out, lock per channel; all_lock registered AND of lock.
module fab_clk_div_gen
   import fab_clk_pkg::*;
#(
   parameter  int NUM_CH   = FAB_NUM_CH,
   parameter  int DIV_W    = FAB_DIV_W,
   parameter  int DEF_DIV  = FAB_DEF_DIV,
   parameter  int LOCK_CNT = FAB_LOCK_CNT,
   localparam int CH_W     = (clog2(NUM_CH) > 0) ? clog2(NUM_CH) : 1
) (
   input  logic              PCLK,
   input  logic              PRESERN,
   input  logic              cfg_wr,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [DIV_W-1:0]  cfg_div,
   output logic              cfg_ready,
   input  logic [NUM_CH-1:0] ch_en,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] lock,
   output logic              all_lock
);
   localparam int CH_N = 1 << CH_W;
   logic [NUM_CH-1:0] pend;
   logic [CH_N-1:0]   pend_x;
   logic              all_lock_q;
   // Zero-padded so every encodable cfg_ch indexes a real bit.
   assign pend_x    = CH_N'(pend);
   assign cfg_ready = (32'(cfg_ch) < NUM_CH) & ~pend_x[cfg_ch];
   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      fab_clk_div_ch #(.DIV_W(DIV_W), .DEF_DIV(DEF_DIV), .LOCK_CNT(LOCK_CNT)) u_ch (
         .PCLK   (PCLK),
         .PRESERN(PRESERN),
         .ch_en  (ch_en[g]),
         .wr     (cfg_wr & cfg_ready & (cfg_ch == CH_W'(g))),
         .wr_div (cfg_div),
         .pend   (pend[g]),
         .tick   (tick[g]),
         .clk_out(clk_out[g]),
         .lock   (lock[g])
      );
   end
   always_ff @(posedge PCLK) begin
      if (!PRESERN) all_lock_q <= 1'b0;
      else all_lock_q <= &lock;
   end
   assign all_lock = all_lock_q;
endmodule

// File: tb/tb_fab_clk_div_gen.sv
// tb_fab_clk_div_gen: table, directed and random checks of fab_clk_div_gen against a time-based model
module tb_fab_clk_div_gen;
   localparam int NC = 3;
   localparam int LK = 4;
   typedef struct {
      int ch;
      int div;
      int first;
      int per;
   } vec_t;
   logic          PCLK = 0, PRESERN = 0, cfg_wr = 0, cfg_ready, all_lock;
   logic [1:0]    cfg_ch = 0;
   logic [15:0]   cfg_div = 0;
   logic [NC-1:0] ch_en = 0, tick, clk_out, lock;
   int tests = 0, fails = 0, n = 0, k;
   vec_t tbl[4];
   int m_div[NC], m_pval[NC], m_next[NC], m_lc[NC], m_last[NC];
   bit m_pend[NC], m_tick[NC], m_clk[NC], m_lock[NC], m_was[NC];
   bit m_all;

   fab_clk_div_gen #(.NUM_CH(NC)) dut (
      .PCLK(PCLK), .PRESERN(PRESERN), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
      .cfg_ready(cfg_ready), .ch_en(ch_en), .tick(tick), .clk_out(clk_out), .lock(lock), .all_lock(all_lock)
   );

   always #5 PCLK = ~PCLK;

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (edge %0d)", nm, act, exp, n);
      end
   endtask

   function automatic bit m_ready(input logic [1:0] c);
      return (c < NC) ? !m_pend[c] : 1'b0;
   endfunction

   // Model: each channel keeps the absolute edge number of its next tick.
   task automatic step();
      bit rdy, rst, wr;
      logic [1:0] c;
      logic [15:0] v;
      logic [NC-1:0] en, pl, et, ec, el;
      rdy = m_ready(cfg_ch);
      rst = PRESERN; wr = cfg_wr; c = cfg_ch; v = cfg_div; en = ch_en;
      for (int i = 0; i < NC; i++) pl[i] = m_lock[i];
      @(posedge PCLK);
      n++;
      if (!rst) begin
         for (int i = 0; i < NC; i++) begin
            m_div[i] = 0; m_pend[i] = 0; m_tick[i] = 0; m_clk[i] = 0;
            m_lc[i] = 0; m_lock[i] = 0; m_was[i] = 0; m_last[i] = -10;
         end
         m_all = 0;
      end else begin
         m_all = &pl;
         for (int i = 0; i < NC; i++) begin
            if (!en[i]) begin
               if (m_pend[i]) begin m_div[i] = m_pval[i]; m_pend[i] = 0; end
               m_tick[i] = 0; m_clk[i] = 0; m_lc[i] = 0; m_was[i] = 0;
            end else begin
               if (!m_was[i]) m_next[i] = n + m_div[i];
               if (m_pend[i] && m_last[i] == n - 1) begin
                  m_div[i] = m_pval[i]; m_pend[i] = 0; m_lc[i] = 0; m_next[i] = n + m_div[i];
               end
               m_tick[i] = (n == m_next[i]);
               if (m_tick[i]) begin
                  m_clk[i] = !m_clk[i];
                  if (m_lc[i] < LK) m_lc[i]++;
                  m_next[i] = n + m_div[i] + 1;
                  m_last[i] = n;
               end
               m_was[i] = 1;
            end
            m_lock[i] = en[i] && m_lc[i] == LK;
         end
         if (wr && rdy) begin m_pend[c] = 1; m_pval[c] = int'(v); end
      end
      #1;
      for (int i = 0; i < NC; i++) begin et[i] = m_tick[i]; ec[i] = m_clk[i]; el[i] = m_lock[i]; end
      chk("tick", int'(tick), int'(et));
      chk("clk_out", int'(clk_out), int'(ec));
      chk("lock", int'(lock), int'(el));
      chk("all_lock", int'(all_lock), int'(m_all));
      chk("cfg_ready", int'(cfg_ready), int'(m_ready(cfg_ch)));
   endtask

   task automatic wait_tick(input int c, output int cnt);
      cnt = 0;
      do begin step(); cnt++; end while (!tick[c] && cnt < 200);
      if (!tick[c]) begin
         tests++; fails++;
         $display("FAIL wait_tick ch%0d: got no tick, required one within 200 cycles", c);
      end
   endtask

   task automatic do_reset();
      PRESERN = 0; cfg_wr = 0; ch_en = 0;
      step(); step();
      PRESERN = 1;
   endtask

   task automatic write(input int c, input int d);
      cfg_wr = 1; cfg_ch = 2'(c); cfg_div = 16'(d);
      step();
      cfg_wr = 0;
   endtask

   initial begin
      tbl[0] = '{1, 3, 4, 4};
      tbl[1] = '{2, 0, 1, 1};
      tbl[2] = '{0, 7, 8, 8};
      tbl[3] = '{2, 2, 3, 3};
      // reset dominates enables and writes
      ch_en = '1; cfg_wr = 1; cfg_ch = 0; cfg_div = 5;
      step(); step();
      cfg_wr = 0;
      #1;
      chk("rst_tick", int'(tick), 0);
      chk("rst_clk", int'(clk_out), 0);
      chk("rst_lock", int'(lock), 0);
      chk("rst_all", int'(all_lock), 0);
      chk("rst_ready", int'(cfg_ready), 1);
      // bypass divisor on ch0 straight out of reset
      ch_en = 3'b001; PRESERN = 1;
      for (int i = 1; i <= 6; i++) begin
         step();
         chk("bypass_tick", int'(tick[0]), 1);
         chk("bypass_clk", int'(clk_out[0]), i % 2);
         chk("bypass_lock", int'(lock[0]), int'(i >= 4));
      end
      // table: first-tick latency and period per divisor
      foreach (tbl[t]) begin
         do_reset();
         write(tbl[t].ch, tbl[t].div);
         step();
         ch_en = NC'(1 << tbl[t].ch);
         wait_tick(tbl[t].ch, k);
         chk("tbl_first", k, tbl[t].first);
         chk("tbl_clk_hi", int'(clk_out[tbl[t].ch]), 1);
         wait_tick(tbl[t].ch, k);
         chk("tbl_per", k, tbl[t].per);
         chk("tbl_clk_lo", int'(clk_out[tbl[t].ch]), 0);
         ch_en = 0;
      end
      // all_lock follows every channel
      do_reset();
      write(1, 3); write(2, 1); step();
      ch_en = 3'b111;
      repeat (30) step();
      chk("all_lock_on", int'(all_lock), 1);
      ch_en = 3'b011;
      step(); step();
      chk("all_lock_off", int'(all_lock), 0);
      // divisor change mid-period on ch2
      do_reset();
      write(2, 9); step();
      ch_en = 3'b100;
      repeat (4) wait_tick(2, k);
      chk("mid_lock", int'(lock[2]), 1);
      repeat (4) step();
      cfg_wr = 1; cfg_ch = 2; cfg_div = 2;
      #1 chk("mid_ready", int'(cfg_ready), 1);
      step();
      cfg_wr = 0;
      chk("mid_busy", int'(cfg_ready), 0);
      wait_tick(2, k);
      chk("mid_old_per", k, 5);
      chk("mid_lock_hold", int'(lock[2]), 1);
      step();
      chk("mid_lock_drop", int'(lock[2]), 0);
      wait_tick(2, k);
      chk("mid_new_per", k, 2);
      repeat (2) wait_tick(2, k);
      chk("mid_relock_no", int'(lock[2]), 0);
      wait_tick(2, k);
      chk("mid_relock", int'(lock[2]), 1);
      // write on a tick, second write refused
      do_reset();
      write(1, 3); step();
      ch_en = 3'b010;
      wait_tick(1, k);
      cfg_wr = 1; cfg_ch = 1; cfg_div = 1;
      #1 chk("tick_wr_ready", int'(cfg_ready), 1);
      step();
      cfg_div = 5;
      #1 chk("second_wr_ready", int'(cfg_ready), 0);
      step();
      cfg_wr = 0;
      wait_tick(1, k);
      chk("tick_wr_same", k, 2);
      wait_tick(1, k);
      chk("tick_wr_new", k, 2);
      wait_tick(1, k);
      chk("second_wr_ignored", k, 2);
      // invalid channel
      cfg_ch = 3; cfg_wr = 1; cfg_div = 7;
      #1 chk("bad_ch_ready", int'(cfg_ready), 0);
      step();
      cfg_wr = 0;
      // reset mid-period discards divisors and pending writes
      do_reset();
      write(1, 5); write(2, 9); step();
      ch_en = 3'b111;
      repeat (3) step();
      write(1, 2);
      PRESERN = 0;
      step();
      chk("mid_rst_tick", int'(tick), 0);
      chk("mid_rst_clk", int'(clk_out), 0);
      chk("mid_rst_lock", int'(lock), 0);
      PRESERN = 1;
      repeat (3) begin
         step();
         chk("post_rst_tick", int'(tick), 7);
      end
      // random traffic
      do_reset();
      ch_en = 3'b111;
      repeat (2500) begin
         int j;
         j = $urandom_range(NC - 1);
         if ($urandom_range(15) == 0) ch_en[j] = ~ch_en[j];
         cfg_wr  = ($urandom_range(3) == 0);
         cfg_ch  = 2'($urandom_range(3));
         cfg_div = 16'($urandom_range(5));
         PRESERN = ($urandom_range(299) != 0);
         step();
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
